// File: rtl/mac_driver_pkg.sv
// mac_driver_pkg -- shared definitions for the MAC engine driver.
//   * operation-width mode encodings (MODE_4/MODE_8/MODE_16/MODE_BAD)
//   * engine status encoding ST_DONE
//   * FSM state enum
//   * bit positions inside eng_control
//   * mask_operand(): zero-masks an operand down to the mode width
package mac_driver_pkg;

  localparam logic [1:0] MODE_4   = 2'b00;
  localparam logic [1:0] MODE_8   = 2'b01;
  localparam logic [1:0] MODE_16  = 2'b11;
  localparam logic [1:0] MODE_BAD = 2'b10;

  localparam logic [1:0] ST_DONE  = 2'b11;

  // eng_control layout: [3]=start, [2]=active-low clear, [1:0]=mode
  localparam int CTL_START   = 3;
  localparam int CTL_CLR_N   = 2;
  localparam int CTL_MODE_HI = 1;
  localparam int CTL_MODE_LO = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

  // Keep only the bits the selected width uses; the illegal mode never
  // reaches the engine, so its operands are driven as zero.
  function automatic logic [31:0] mask_operand(input logic [31:0] value,
                                               input logic [1:0]  mode);
    logic [31:0] masked;
    masked = '0;
    case (mode)
      MODE_4:  masked = {28'd0, value[3:0]};
      MODE_8:  masked = {24'd0, value[7:0]};
      MODE_16: masked = {16'd0, value[15:0]};
      default: masked = '0;
    endcase
    return masked;
  endfunction

endpackage

// File: rtl/mac_driver_if.sv
// mac_driver_if -- request/response handshake bundle of the MAC driver.
//   req_valid/req_ready : request handshake (requester -> driver)
//   req_mode            : operation width (see mac_driver_pkg)
//   req_a..req_d        : operands
//   resp_valid/resp_ready : response handshake (driver -> requester)
//   resp_result         : dot-product result
//   resp_err            : illegal mode or engine timeout
// Modports: master = requester side, slave = mac_driver side.
interface mac_driver_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_mode;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] req_c;
  logic [31:0] req_d;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_err;

  modport master (
    output req_valid, req_mode, req_a, req_b, req_c, req_d, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_err
  );

  modport slave (
    input  req_valid, req_mode, req_a, req_b, req_c, req_d, resp_ready,
    output req_ready, resp_valid, resp_result, resp_err
  );
endinterface

// File: rtl/mac_driver.sv
// mac_driver -- sequences one dot-product operation through an external
// MAC engine per request and returns the result (or an error) on a
// response handshake.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   bus (slave)        : request/response handshake bundle
//   eng_control[3:0]   : [3]=start, [2]=active-low clear, [1:0]=mode
//   eng_a..eng_d       : width-masked operands to the engine
//   eng_status, eng_result : engine status (11 = result valid) and result
//   busy               : FSM is not in IDLE
//   ops_done           : count of error-free responses (wraps)
// Parameters:
//   TIMEOUT : WAIT cycles allowed before an error response
//   OPS_W   : width of ops_done
module mac_driver
  import mac_driver_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int OPS_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mac_driver_if.slave       bus,
  output logic [3:0]        eng_control,
  output logic [31:0]       eng_a,
  output logic [31:0]       eng_b,
  output logic [31:0]       eng_c,
  output logic [31:0]       eng_d,
  input  logic [1:0]        eng_status,
  input  logic [31:0]       eng_result,
  output logic              busy,
  output logic [OPS_W-1:0]  ops_done
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state_reg;
  logic               start_reg;
  logic               clr_n_reg;
  logic [1:0]         mode_reg;
  logic [31:0]        eng_a_reg, eng_b_reg, eng_c_reg, eng_d_reg;
  logic               req_ready_reg;
  logic               resp_valid_reg;
  logic [31:0]        resp_result_reg;
  logic               resp_err_reg;
  logic               busy_reg;
  logic [OPS_W-1:0]   ops_done_reg;
  logic [CNT_W-1:0]   wait_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      start_reg       <= 1'b0;
      clr_n_reg       <= 1'b0;   // engine held in clear during reset
      mode_reg        <= 2'b00;
      eng_a_reg       <= '0;
      eng_b_reg       <= '0;
      eng_c_reg       <= '0;
      eng_d_reg       <= '0;
      req_ready_reg   <= 1'b0;
      resp_valid_reg  <= 1'b0;
      resp_result_reg <= '0;
      resp_err_reg    <= 1'b0;
      busy_reg        <= 1'b0;
      ops_done_reg    <= '0;
      wait_cnt_reg    <= '0;
    end else begin
      clr_n_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          req_ready_reg <= 1'b1;
          // req_ready_reg is 0 on the first cycle out of reset, so no
          // request can be taken before the driver advertises readiness.
          if (bus.req_valid && req_ready_reg) begin
            req_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            mode_reg      <= bus.req_mode;
            eng_a_reg     <= mask_operand(bus.req_a, bus.req_mode);
            eng_b_reg     <= mask_operand(bus.req_b, bus.req_mode);
            eng_c_reg     <= mask_operand(bus.req_c, bus.req_mode);
            eng_d_reg     <= mask_operand(bus.req_d, bus.req_mode);
            if (bus.req_mode == MODE_BAD) begin
              state_reg       <= RESP;
              resp_valid_reg  <= 1'b1;
              resp_err_reg    <= 1'b1;
              resp_result_reg <= '0;
            end else begin
              state_reg <= ISSUE;
              start_reg <= 1'b1;
            end
          end
        end

        // Engine status is not looked at here: anything it reports now is
        // left over from before this start pulse.
        ISSUE: begin
          state_reg    <= WAIT;
          wait_cnt_reg <= '0;
        end

        WAIT: begin
          if (eng_status == ST_DONE) begin
            resp_result_reg <= eng_result;
            start_reg       <= 1'b0;
            state_reg       <= DRAIN;
          end else if (wait_cnt_reg == CNT_LAST) begin
            start_reg       <= 1'b0;
            state_reg       <= RESP;
            resp_valid_reg  <= 1'b1;
            resp_err_reg    <= 1'b1;
            resp_result_reg <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end

        // One cycle with start low so the engine drops its status to 00
        // before the next operation can begin.
        DRAIN: begin
          state_reg      <= RESP;
          resp_valid_reg <= 1'b1;
          resp_err_reg   <= 1'b0;
        end

        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            req_ready_reg  <= 1'b1;
            state_reg      <= IDLE;
            if (!resp_err_reg) begin
              ops_done_reg <= ops_done_reg + 1'b1;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign eng_control[CTL_START]               = start_reg;
  assign eng_control[CTL_CLR_N]               = clr_n_reg;
  assign eng_control[CTL_MODE_HI:CTL_MODE_LO] = mode_reg;

  assign eng_a = eng_a_reg;
  assign eng_b = eng_b_reg;
  assign eng_c = eng_c_reg;
  assign eng_d = eng_d_reg;

  assign bus.req_ready   = req_ready_reg;
  assign bus.resp_valid  = resp_valid_reg;
  assign bus.resp_result = resp_result_reg;
  assign bus.resp_err    = resp_err_reg;

  assign busy     = busy_reg;
  assign ops_done = ops_done_reg;

endmodule

// File: tb/tb_mac_driver.sv
// tb_mac_driver -- table-driven bench for mac_driver with a small engine
// stub computing a*c + b*d, plus a hand-written mid-operation reset case.
module tb_mac_driver;
  import mac_driver_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int OPS_W   = 16;

  logic              clk;
  logic              rst_n;
  logic [3:0]        eng_control;
  logic [31:0]       eng_a, eng_b, eng_c, eng_d;
  logic [1:0]        eng_status;
  logic [31:0]       eng_result;
  logic              busy;
  logic [OPS_W-1:0]  ops_done;

  mac_driver_if bus ();

  mac_driver #(.TIMEOUT(TIMEOUT), .OPS_W(OPS_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .eng_control (eng_control),
    .eng_a       (eng_a),
    .eng_b       (eng_b),
    .eng_c       (eng_c),
    .eng_d       (eng_d),
    .eng_status  (eng_status),
    .eng_result  (eng_result),
    .busy        (busy),
    .ops_done    (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine stub: answers one cycle after it sees start; hold forces 00,
  // stale_en overrides the outputs with a bogus "done".
  logic        stub_hold;
  logic        stale_en;
  logic [1:0]  stub_status_q;
  logic [31:0] stub_result_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_status_q <= 2'b00;
      stub_result_q <= 32'd0;
    end else if (eng_control[3] && !stub_hold) begin
      stub_status_q <= 2'b11;
      stub_result_q <= eng_a * eng_c + eng_b * eng_d;
    end else begin
      stub_status_q <= 2'b00;
    end
  end

  assign eng_status = stale_en ? 2'b11 : stub_status_q;
  assign eng_result = stale_en ? 32'hDEADBEEF : stub_result_q;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] a, b, c, d;
    logic [31:0] ea, eb, ec, ed;
    logic [31:0] result;
    logic        err;
    int          lat;
    bit          hang;
    bit          stale;
  } vec_t;

  int checks;
  int errors;
  int exp_ops;
  int txn_id;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int hold;
    logic [3:0] exp_ctl;
    lat = 0;
    stub_hold = v.hang;
    @(negedge clk);
    check("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_mode  = v.mode;
    bus.req_a = v.a; bus.req_b = v.b; bus.req_c = v.c; bus.req_d = v.d;
    @(posedge clk);            // edge k: request accepted
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (v.stale) stale_en = 1'b1;
    exp_ctl = {(v.mode != MODE_BAD), 1'b1, v.mode};
    check("eng_control_k", {28'd0, eng_control}, {28'd0, exp_ctl});
    check("eng_a", eng_a, v.ea);
    check("eng_b", eng_b, v.eb);
    check("eng_c", eng_c, v.ec);
    check("eng_d", eng_d, v.ed);
    check("busy_k", {31'd0, busy}, 32'd1);
    check("req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1 stale_en = 1'b0;
      @(negedge clk);
      if (n == 1)
        check("start_k1", {31'd0, eng_control[3]}, {31'd0, (v.mode != MODE_BAD)});
      if (bus.resp_valid) begin
        lat = n;
        break;
      end
    end
    check("latency", lat, v.lat);
    check("start_low_resp", {31'd0, eng_control[3]}, 32'd0);
    check("resp_result", bus.resp_result, v.result);
    check("resp_err", {31'd0, bus.resp_err}, {31'd0, v.err});
    hold = v.hang ? 5 : 1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", {31'd0, bus.resp_valid}, 32'd1);
      check("hold_result", bus.resp_result, v.result);
      check("hold_err", {31'd0, bus.resp_err}, {31'd0, v.err});
      check("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    if (!v.err) exp_ops++;
    check("resp_valid_after_hs", {31'd0, bus.resp_valid}, 32'd0);
    check("req_ready_after_hs", {31'd0, bus.req_ready}, 32'd1);
    check("busy_after_hs", {31'd0, busy}, 32'd0);
    check("ops_done", {16'd0, ops_done}, exp_ops[31:0]);
    $display("txn %0d mode=%b result=0x%08h err=%b lat=%0d ops_done=%0d",
             txn_id, v.mode, v.result, v.err, lat, ops_done);
    txn_id++;
    stub_hold = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    checks = 0; errors = 0; exp_ops = 0; txn_id = 0;
    stub_hold = 1'b0; stale_en = 1'b0;
    bus.req_valid = 1'b0; bus.req_mode = 2'b00; bus.resp_ready = 1'b0;
    bus.req_a = '0; bus.req_b = '0; bus.req_c = '0; bus.req_d = '0;

    //            mode   a             b             c             d
    //            ea     eb  ec  ed    result  err lat hang stale
    vecs[0] = '{2'b00, 32'd3, 32'd4, 32'd5, 32'd6,
                32'd3, 32'd4, 32'd5, 32'd6, 32'h27, 1'b0, 3, 1'b0, 1'b0};
    vecs[1] = '{2'b01, 32'hABCD12FF, 32'h12340002, 32'h000011FF, 32'hFFFFFF03,
                32'hFF, 32'h02, 32'hFF, 32'h03, 32'hFE07, 1'b0, 3, 1'b0, 1'b0};
    vecs[2] = '{2'b11, 32'h0000FFFF, 32'hFFFFFFFF, 32'h0000FFFF, 32'h1234FFFF,
                32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFC0002, 1'b0, 3, 1'b0, 1'b0};
    vecs[3] = '{2'b00, 32'h1F, 32'h2E, 32'h3D, 32'h4C,
                32'hF, 32'hE, 32'hD, 32'hC, 32'h16B, 1'b0, 3, 1'b0, 1'b1};
    vecs[4] = '{2'b10, 32'h12345678, 32'h9, 32'hA, 32'hB,
                32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1, 1'b0, 1'b0};
    vecs[5] = '{2'b11, 32'h00010100, 32'h00001234, 32'h00000200, 32'h00000010,
                32'h0100, 32'h1234, 32'h0200, 32'h0010, 32'h00032340, 1'b0, 3, 1'b0, 1'b0};
    vecs[6] = '{2'b01, 32'd5, 32'd6, 32'd7, 32'd8,
                32'd5, 32'd6, 32'd7, 32'd8, 32'd0, 1'b1, TIMEOUT + 1, 1'b1, 1'b0};

    // Reset state
    rst_n = 1'b0;
    #12;
    check("rst_eng_control", {28'd0, eng_control}, 32'd0);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ops_done", {16'd0, ops_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("post_rst_eng_control", {28'd0, eng_control}, 32'h4);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset asserted while the engine is stuck in WAIT
    stub_hold = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_mode = 2'b11;
    bus.req_a = 32'h11; bus.req_b = 32'h22; bus.req_c = 32'h33; bus.req_d = 32'h44;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("mid_wait_start", {31'd0, eng_control[3]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_eng_control", {28'd0, eng_control}, 32'd0);
    check("midrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_eng_a", eng_a, 32'd0);
    check("midrst_ops_done", {16'd0, ops_done}, 32'd0);
    exp_ops = 0;
    $display("txn %0d mid-WAIT reset applied", txn_id);
    txn_id++;
    @(negedge clk);
    rst_n = 1'b1;
    stub_hold = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("after_midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
